fir4_unsum: RTL and testbench

- Inverse of the 4-tap signed moving-sum FIR (s[n] = a[n]+a[n-1]+a[n-2]+a[n-3]).
- Recovers the original W-bit samples from the W+2-bit sum stream using a[n] = s[n] - s[n-1] + a[n-4].
- Sits at the receive end of a filtered sample link. Also used as a self-check: fir4 output drives unsum input, and unsum output must match the fir4 input stream.
- Valid/ready on both sides, one registered output stage, sticky range-error flag.

---
 rtl/fir4_unsum_if.sv | 24 ++
 rtl/fir4_unsum.sv | 85 ++++++++
 tb/tb_fir4_unsum.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir4_unsum_if.sv
// Stream bundle for fir4_unsum: sum input (s side), recovered sample output
// (a side) and status. The upstream/downstream user takes master, the block takes slave.
interface fir4_unsum_if #(
  parameter int W = 16
);
  logic                s_valid;
  logic                s_ready;
  logic signed [W+1:0] s;
  logic                a_valid;
  logic                a_ready;
  logic signed [W-1:0] a;
  logic                err;
  logic [15:0]         cnt;

  modport master (
    output s_valid, s, a_ready,
    input  s_ready, a_valid, a, err, cnt
  );

  modport slave (
    input  s_valid, s, a_ready,
    output s_ready, a_valid, a, err, cnt
  );
endinterface

// File: rtl/fir4_unsum.sv
// Inverse of the 4-tap moving-sum FIR: a[n] = s[n] - s[n-1] + a[n-4], one registered stage.
// Define FIR4_UNSUM_SAT_EN to saturate out-of-range results instead of wrapping them.
module fir4_unsum #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          reset,
  fir4_unsum_if.slave   io_bus
);
  localparam int TW = W + 4;
  localparam logic signed [TW-1:0] LP_MAX = {5'b00000, {(W-1){1'b1}}};
  localparam logic signed [TW-1:0] LP_MIN = {5'b11111, {(W-1){1'b0}}};

  logic signed [W+1:0] r_s_prev;
  logic signed [W-1:0] r_hist [4];
  logic signed [W-1:0] r_a;
  logic                r_a_valid;
  logic                r_err;
  logic [15:0]         r_cnt;

  logic                w_s_ready;
  logic                w_accept;
  logic                w_transfer;
  logic signed [TW-1:0] w_t;
  logic                w_ovf;
  logic signed [W-1:0] w_a_new;

  assign w_s_ready  = !r_a_valid || io_bus.a_ready;
  assign w_accept   = io_bus.s_valid && w_s_ready;
  assign w_transfer = r_a_valid && io_bus.a_ready;

  // W+4 bits hold the full range of s - s_prev + a[n-4] without overflow
  assign w_t = $signed({{2{io_bus.s[W+1]}}, io_bus.s})
             - $signed({{2{r_s_prev[W+1]}}, r_s_prev})
             + $signed({{4{r_hist[3][W-1]}}, r_hist[3]});

  assign w_ovf = (w_t > LP_MAX) || (w_t < LP_MIN);

  always_comb begin
    w_a_new = w_t[W-1:0];
`ifdef FIR4_UNSUM_SAT_EN
    if (w_t > LP_MAX) begin
      w_a_new = LP_MAX[W-1:0];
    end else if (w_t < LP_MIN) begin
      w_a_new = LP_MIN[W-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_prev  <= '0;
      r_a       <= '0;
      r_a_valid <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_s_prev  <= io_bus.s;
        r_a       <= w_a_new;
        r_a_valid <= 1'b1;
        r_cnt     <= r_cnt + 16'd1;
        // history keeps the value actually emitted so the recursion tracks the output
        r_hist[0] <= w_a_new;
        for (int i = 1; i < 4; i++) begin
          r_hist[i] <= r_hist[i-1];
        end
        if (w_ovf) begin
          r_err <= 1'b1;
        end
      end else if (w_transfer) begin
        r_a_valid <= 1'b0;
      end
    end
  end

  assign io_bus.s_ready = w_s_ready;
  assign io_bus.a_valid = r_a_valid;
  assign io_bus.a       = r_a;
  assign io_bus.err     = r_err;
  assign io_bus.cnt     = r_cnt;
endmodule

// File: tb/tb_fir4_unsum.sv
// Directed bench for fir4_unsum: reference model compared every cycle plus literal expectations.
module tb_fir4_unsum;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  bit   started;

  fir4_unsum_if #(.W(16)) bus ();

  fir4_unsum #(.W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state (plain integers)
  longint  m_sprev;
  longint  m_hist [4];
  longint  m_a;
  bit      m_valid;
  bit      m_err;
  bit [15:0] m_cnt;
  longint  rx [$];

  function automatic longint f_raw(longint sv, longint sp, longint h3);
    return sv - sp + h3;
  endfunction

  function automatic bit f_oor(longint t);
    return (t > 32767) || (t < -32768);
  endfunction

  function automatic longint f_fit(longint t);
`ifdef FIR4_UNSUM_SAT_EN
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
`else
    longint m;
    m = (t + 32768) % 65536;
    if (m < 0) m = m + 65536;
    return m - 32768;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_sprev <= 0;
      m_a     <= 0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= '0;
      for (int i = 0; i < 4; i++) m_hist[i] <= 0;
      started <= 1'b1;
    end else if (started) begin
      if (bus.s_valid && (!m_valid || bus.a_ready)) begin
        m_sprev   <= longint'(bus.s);
        m_a       <= f_fit(f_raw(longint'(bus.s), m_sprev, m_hist[3]));
        m_hist[0] <= f_fit(f_raw(longint'(bus.s), m_sprev, m_hist[3]));
        m_hist[1] <= m_hist[0];
        m_hist[2] <= m_hist[1];
        m_hist[3] <= m_hist[2];
        m_err     <= m_err || f_oor(f_raw(longint'(bus.s), m_sprev, m_hist[3]));
        m_cnt     <= m_cnt + 16'd1;
        m_valid   <= 1'b1;
      end else if (m_valid && bus.a_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // capture every output transfer as the DUT presents it
  always @(posedge clk) begin
    if (!reset && started && bus.a_valid === 1'b1 && bus.a_ready)
      rx.push_back(longint'(bus.a));
  end

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("a_valid", longint'(bus.a_valid), longint'(m_valid));
      check("s_ready", longint'(bus.s_ready), longint'(!m_valid || bus.a_ready));
      check("err", longint'(bus.err), longint'(m_err));
      check("cnt", longint'(bus.cnt), longint'(m_cnt));
      check("a", longint'(bus.a), m_a);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    reset = 1'b0;
    rx.delete();
  endtask

  task automatic send(input longint v);
    bit acc;
    bus.s = v[17:0];
    bus.s_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = !m_valid || bus.a_ready;
      tick();
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_rx(input string name, input longint exp[$]);
    check({name, "_count"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++)
      check(name, rx[i], exp[i]);
  endtask

  initial begin
    longint exp_q [$];
    longint src [$];
    longint win [4];
    logic signed [15:0] smp;
    longint sum;
    bit acc;
    int guard;

    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s = '0;
    bus.a_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rx.delete();

    // basic ramp
    check("reset_a_valid", longint'(bus.a_valid), 0);
    check("reset_cnt", longint'(bus.cnt), 0);
    send(1); send(3); send(6); send(10); send(14); send(18);
    idle(2);
    exp_q = '{1, 2, 3, 4, 5, 6};
    check_rx("basic", exp_q);
    check("basic_err", longint'(bus.err), 0);
    check("basic_cnt", longint'(bus.cnt), 6);

    // negative extreme
    do_reset();
    send(-32768); send(-65536); send(-98304); send(-131072); send(-131072);
    idle(2);
    exp_q = '{-32768, -32768, -32768, -32768, -32768};
    check_rx("neg", exp_q);
    check("neg_err", longint'(bus.err), 0);

    // backpressure
    do_reset();
    send(5);
    bus.a_ready = 1'b0;
    bus.s = 18'sd12;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_s_ready", longint'(bus.s_ready), 0);
      check("bp_hold_a", longint'(bus.a), 5);
    end
    bus.a_ready = 1'b1;
    tick();
    check("bp_second_a", longint'(bus.a), 7);
    idle(2);
    exp_q = '{5, 7};
    check_rx("bp", exp_q);
    check("bp_cnt", longint'(bus.cnt), 2);

    // overflow
    do_reset();
    send(40000);
`ifdef FIR4_UNSUM_SAT_EN
    check("ovf_a", longint'(bus.a), 32767);
`else
    check("ovf_a", longint'(bus.a), -25536);
`endif
    check("ovf_err", longint'(bus.err), 1);
    idle(3);
    check("ovf_err_sticky", longint'(bus.err), 1);

    // reset mid-stream
    do_reset();
    send(1); send(3); send(6);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    check("rst_mid_a_valid", longint'(bus.a_valid), 0);
    reset = 1'b0;
    rx.delete();
    tick();
    check("rst_after_a_valid", longint'(bus.a_valid), 0);
    send(2); send(4);
    idle(2);
    exp_q = '{2, 2};
    check_rx("rst_mid", exp_q);
    check("rst_mid_cnt", longint'(bus.cnt), 2);

    // loopback through a behavioural 4-tap moving sum, with random ready
    do_reset();
    src.delete();
    for (int i = 0; i < 4; i++) win[i] = 0;
    for (int n = 0; n < 25; n++) begin
      smp = 16'($urandom);
      src.push_back(longint'(smp));
      win[3] = win[2]; win[2] = win[1]; win[1] = win[0]; win[0] = longint'(smp);
      sum = win[0] + win[1] + win[2] + win[3];
      bus.s = sum[17:0];
      bus.s_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        bus.a_ready = ($urandom_range(0, 3) != 0);
        acc = !m_valid || bus.a_ready;
        tick();
        guard++;
      end
      if (!acc) check("loop_timeout", 0, 1);
    end
    bus.a_ready = 1'b1;
    idle(3);
    check_rx("loop", src);
    check("loop_err", longint'(bus.err), 0);
    check("loop_cnt", longint'(bus.cnt), 25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
